// File: rtl/std_cache_pkg.sv
// std_cache_pkg: shared write-back data cache geometry, used by the SRAM, the miss handler and the flush unit.
package std_cache_pkg;
    localparam int unsigned DCACHE_NR_SETS    = 256;
    localparam int unsigned DCACHE_NR_WAYS    = 8;
    localparam int unsigned DCACHE_LINE_WIDTH = 128;
    localparam int unsigned DCACHE_TAG_WIDTH  = 44;

    // Width of an index over n items; a single item still needs a one-bit field.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DCACHE_IDX_WIDTH    = idx_width(DCACHE_NR_SETS);
    localparam int unsigned DCACHE_WAY_WIDTH    = idx_width(DCACHE_NR_WAYS);
    localparam int unsigned DCACHE_OFFSET_WIDTH = idx_width(DCACHE_LINE_WIDTH / 8);
endpackage

// File: rtl/lzc.sv
// lzc: zero counter, trailing zeros (MODE=0) or leading zeros (MODE=1); yields 0 for an all-zero input.
module lzc #(
    parameter int unsigned WIDTH = 2,
    parameter bit          MODE  = 1'b0,
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o
);
    // Scan from the far end so the set bit nearest the counted end wins.
    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (in_i[MODE ? (WIDTH - 1 - i) : i]) cnt_o = CNT_W'(i);
    end
endmodule

// File: rtl/dcache_flush_unit.sv
// dcache_flush_unit: walks every set of the write-back data cache, writes back valid+dirty lines,
// invalidates each set and pulses flush_ack_o once the walk is complete.
module dcache_flush_unit
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_SETS    = DCACHE_NR_SETS,
    parameter int unsigned NR_WAYS    = DCACHE_NR_WAYS,
    parameter int unsigned LINE_WIDTH = DCACHE_LINE_WIDTH,
    parameter int unsigned TAG_WIDTH  = DCACHE_TAG_WIDTH,
    localparam int unsigned IDX_W      = idx_width(NR_SETS),
    localparam int unsigned WAY_W      = idx_width(NR_WAYS),
    localparam int unsigned OFF_W      = idx_width(LINE_WIDTH / 8),
    localparam int unsigned ADDR_WIDTH = TAG_WIDTH + IDX_W + OFF_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    output logic                         flush_ack_o,
    output logic                         busy_o,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [IDX_W-1:0]             sram_idx_o,
    output logic [WAY_W-1:0]             sram_way_o,
    input  logic                         sram_gnt_i,
    input  logic [NR_WAYS-1:0]           valid_i,
    input  logic [NR_WAYS-1:0]           dirty_i,
    input  logic [NR_WAYS*TAG_WIDTH-1:0] tag_i,
    input  logic [LINE_WIDTH-1:0]        data_i,
    output logic                         wb_req_o,
    output logic [ADDR_WIDTH-1:0]        wb_addr_o,
    output logic [LINE_WIDTH-1:0]        wb_data_o,
    input  logic                         wb_gnt_i
);
    typedef enum logic [2:0] {IDLE, META_REQ, META_WAIT, DATA_REQ, DATA_WAIT, WB, INV, DONE} state_e;

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NR_WAYS-1:0]           mask_q, mask_d;
    logic [NR_WAYS*TAG_WIDTH-1:0] tags_q, tags_d;
    logic [LINE_WIDTH-1:0]        line_q, line_d;
    logic                         ack_q;
    logic [WAY_W-1:0]             way;
    logic [NR_WAYS-1:0]           way_oh;

    lzc #(.WIDTH(NR_WAYS), .MODE(1'b0)) i_lzc (.in_i(mask_q), .cnt_o(way));

    assign way_oh = NR_WAYS'(1) << way;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        tags_d  = tags_q;
        line_d  = line_q;
        case (state_q)
            IDLE: if (flush_i && !ack_q) begin
                idx_d   = '0;
                state_d = META_REQ;
            end
            META_REQ: state_d = sram_gnt_i ? META_WAIT : META_REQ;
            META_WAIT: begin
                mask_d  = valid_i & dirty_i;
                tags_d  = tag_i;
                state_d = |(valid_i & dirty_i) ? DATA_REQ : INV;
            end
            DATA_REQ: state_d = sram_gnt_i ? DATA_WAIT : DATA_REQ;
            DATA_WAIT: begin
                line_d  = data_i;
                state_d = WB;
            end
            WB: if (wb_gnt_i) begin
                mask_d  = mask_q & ~way_oh;
                state_d = |(mask_q & ~way_oh) ? DATA_REQ : INV;
            end
            INV: if (sram_gnt_i) begin
                idx_d   = (idx_q == IDX_W'(NR_SETS - 1)) ? idx_q : idx_q + 1'b1;
                state_d = (idx_q == IDX_W'(NR_SETS - 1)) ? DONE : META_REQ;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            tags_q  <= '0;
            line_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            tags_q  <= tags_d;
            line_q  <= line_d;
            ack_q   <= (state_q == DONE);
        end
    end

    // Address and data fields are zeroed outside their request so an idle unit drives nothing.
    assign flush_ack_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign sram_req_o  = (state_q == META_REQ) || (state_q == DATA_REQ) || (state_q == INV);
    assign sram_we_o   = (state_q == INV);
    assign sram_idx_o  = sram_req_o ? idx_q : '0;
    assign sram_way_o  = (state_q == DATA_REQ) ? way : '0;
    assign wb_req_o    = (state_q == WB);
    assign wb_addr_o   = wb_req_o ? {tags_q[way*TAG_WIDTH +: TAG_WIDTH], idx_q, {OFF_W{1'b0}}} : '0;
    assign wb_data_o   = wb_req_o ? line_q : '0;
endmodule

// File: tb/tb_dcache_flush_unit.sv
// tb_dcache_flush_unit: small SRAM/writeback model around the flush unit with a scoreboard of expected writebacks.
module tb_dcache_flush_unit;
    localparam int SETS = 4;
    localparam int WAYS = 2;
    localparam int TW   = 8;
    localparam int LW   = 128;
    localparam int AW   = 14;

    logic                 clk = 1'b0;
    logic                 rst_i, flush_i, flush_ack_o, busy_o;
    logic                 sram_req_o, sram_we_o, sram_gnt_i;
    logic [1:0]           sram_idx_o;
    logic [0:0]           sram_way_o;
    logic [WAYS-1:0]      valid_i, dirty_i;
    logic [WAYS*TW-1:0]   tag_i;
    logic [LW-1:0]        data_i, wb_data_o;
    logic                 wb_req_o, wb_gnt_i;
    logic [AW-1:0]        wb_addr_o;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } wb_t;

    wb_t           exp_q[$];
    wb_t           got_e;
    logic          mv[SETS][WAYS];
    logic          md[SETS][WAYS];
    logic [TW-1:0] mt[SETS][WAYS];
    logic [LW-1:0] mdat[SETS][WAYS];
    int            inv_cnt[SETS];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            wb_stall = 0;
    int            n_acks = 0;
    int            acks_before;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dcache_flush_unit #(.NR_SETS(SETS), .NR_WAYS(WAYS), .LINE_WIDTH(LW), .TAG_WIDTH(TW)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .flush_ack_o(flush_ack_o), .busy_o(busy_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_idx_o(sram_idx_o), .sram_way_o(sram_way_o),
        .sram_gnt_i(sram_gnt_i), .valid_i(valid_i), .dirty_i(dirty_i), .tag_i(tag_i), .data_i(data_i),
        .wb_req_o(wb_req_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_gnt_i(wb_gnt_i)
    );

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w]   = 1'b0;
                md[s][w]   = 1'b0;
                mt[s][w]   = '0;
                mdat[s][w] = '0;
            end
    endtask

    task automatic set_line(input int s, input int w, input logic v, input logic d,
                            input logic [TW-1:0] t, input logic [LW-1:0] dat);
        mv[s][w]   = v;
        md[s][w]   = d;
        mt[s][w]   = t;
        mdat[s][w] = dat;
    endtask

    // SRAM returns metadata/data the cycle after a granted read; writeback grants may be withheld.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (flush_ack_o) n_acks++;
            if (sram_req_o && sram_gnt_i) begin
                if (sram_we_o) begin
                    inv_cnt[sram_idx_o]++;
                    for (int w = 0; w < WAYS; w++) begin
                        mv[sram_idx_o][w] = 1'b0;
                        md[sram_idx_o][w] = 1'b0;
                    end
                end else begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_i[w]         = mv[sram_idx_o][w];
                        dirty_i[w]         = md[sram_idx_o][w];
                        tag_i[w*TW +: TW]  = mt[sram_idx_o][w];
                    end
                    data_i = mdat[sram_idx_o][sram_way_o];
                end
            end
            if (wb_req_o) begin
                if (exp_q.size() == 0) begin
                    check("wb_expected", 128'(wb_req_o), 128'(0));
                end else if (wb_stall > 0) begin
                    wb_gnt_i = 1'b0;
                    wb_stall--;
                    check("stall_addr", 128'(wb_addr_o), 128'(exp_q[0].addr));
                    check("stall_data", wb_data_o, exp_q[0].data);
                end else begin
                    wb_gnt_i = 1'b1;
                    got_e = exp_q.pop_front();
                    check("wb_addr", 128'(wb_addr_o), 128'(got_e.addr));
                    check("wb_data", wb_data_o, got_e.data);
                end
            end
        end
    end

    // Holds flush_i through the ack and one cycle beyond, then checks the unit stays idle.
    task automatic run_flush(input string tag, input int exp_cyc);
        int start;
        int got;
        for (int s = 0; s < SETS; s++) inv_cnt[s] = 0;
        flush_i = 1'b1;
        start   = cyc;
        got     = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (flush_ack_o) begin
                got = cyc - start;
                break;
            end
        end
        check({tag, "_ack"}, 128'(flush_ack_o), 128'(1));
        check({tag, "_lat"}, 128'(got), 128'(exp_cyc));
        @(negedge clk);
        check({tag, "_busy1"}, 128'(busy_o), 128'(0));
        check({tag, "_pulse"}, 128'(flush_ack_o), 128'(0));
        @(negedge clk);
        check({tag, "_busy2"}, 128'(busy_o), 128'(0));
        flush_i = 1'b0;
        for (int s = 0; s < SETS; s++) check($sformatf("%s_inv%0d", tag, s), 128'(inv_cnt[s]), 128'(1));
        check({tag, "_q_empty"}, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; sram_gnt_i = 1'b1; wb_gnt_i = 1'b1;
        valid_i = '0; dirty_i = '0; tag_i = '0; data_i = '0;
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_ack", 128'(flush_ack_o), 128'(0));
        check("rst_sram", 128'({sram_req_o, sram_we_o, sram_idx_o, sram_way_o}), 128'(0));
        check("rst_wb", 128'({wb_req_o, wb_addr_o}), 128'(0));
        rst_i = 1'b0;
        @(negedge clk);

        run_flush("clean", 13);

        clear_model();
        set_line(2, 1, 1'b1, 1'b1, 8'h05, {16{8'hA5}});
        exp_q.push_back('{addr: 14'h160, data: {16{8'hA5}}});
        run_flush("one_dirty", 16);

        clear_model();
        set_line(0, 0, 1'b1, 1'b1, 8'h11, {16{8'h11}});
        set_line(0, 1, 1'b1, 1'b1, 8'h22, {16{8'h22}});
        exp_q.push_back('{addr: 14'h440, data: {16{8'h11}}});
        exp_q.push_back('{addr: 14'h880, data: {16{8'h22}}});
        wb_stall = 5;
        run_flush("stall", 24);

        clear_model();
        set_line(3, 0, 1'b0, 1'b1, 8'h77, {16{8'h77}});
        set_line(3, 1, 1'b1, 1'b0, 8'h66, {16{8'h66}});
        run_flush("dirty_invalid", 13);

        clear_model();
        set_line(1, 0, 1'b1, 1'b1, 8'h33, {16{8'h3C}});
        exp_q.push_back('{addr: 14'hCD0, data: {16{8'h3C}}});
        acks_before = n_acks;
        flush_i = 1'b1;
        for (int i = 0; i < 100 && !wb_req_o; i++) begin
            @(posedge clk);
            #1;
        end
        check("mid_wb_req", 128'(wb_req_o), 128'(1));
        check("mid_wb_addr", 128'(wb_addr_o), 128'(14'hCD0));
        rst_i   = 1'b1;
        flush_i = 1'b0;
        #1;
        check("rst_mid_busy", 128'(busy_o), 128'(0));
        check("rst_mid_sram", 128'({sram_req_o, sram_we_o, sram_idx_o, sram_way_o}), 128'(0));
        check("rst_mid_wb", 128'({wb_req_o, wb_addr_o}), 128'(0));
        check("rst_mid_data", wb_data_o, 128'(0));
        repeat (3) @(negedge clk);
        check("rst_no_ack", 128'(n_acks), 128'(acks_before));
        rst_i = 1'b0;
        @(negedge clk);
        run_flush("restart", 16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
